// File: rtl/display_mux_driver_pkg.sv
// Shared definitions for the clock display: digit-word field positions,
// scan state encoding and the all-off segment/anode pattern.
package clock_display_pkg;

    localparam int DW_EN     = 5;
    localparam int DW_VAL_HI = 4;
    localparam int DW_VAL_LO = 1;
    localparam int DW_DP     = 0;

    localparam int DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [5:0] digit_word_t;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/display_mux_driver_if.sv
// Bundle between the clock core (master) and the display scanner (slave):
// eight digit words plus blink controls in, multiplexed display lines out.
interface display_mux_driver_if;
    import clock_display_pkg::*;

    digit_word_t d1;
    digit_word_t d2;
    digit_word_t d3;
    digit_word_t d4;
    digit_word_t d5;
    digit_word_t d6;
    digit_word_t d7;
    digit_word_t d8;
    logic [7:0]  blink_mask;
    logic        blink_hide;
    logic [7:0]  an;
    logic [7:0]  cat;
    logic        frame_start;

    modport master (
        output d1, d2, d3, d4, d5, d6, d7, d8, blink_mask, blink_hide,
        input  an, cat, frame_start
    );

    modport slave (
        input  d1, d2, d3, d4, d5, d6, d7, d8, blink_mask, blink_hide,
        output an, cat, frame_start
    );

endinterface

// File: rtl/display_mux_driver_hex_to_seg7.sv
// Active-low seven-segment decoder, output ordered {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_value)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_mux_driver.sv
// Time-multiplexed common-anode 8-digit display scanner with per-slot
// blanking gap, frame-coherent digit snapshot and per-digit blinking.
module display_mux_driver
    import clock_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input logic clock,
    input logic reset,
    display_mux_driver_if.slave io_disp
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES - 1);

    scan_state_t   r_state;
    scan_state_t   w_nextState;
    logic [CW-1:0] r_slotCount;
    logic [2:0]    r_digitIdx;
    digit_word_t   r_snap [DIGITS];
    logic [7:0]    r_an;
    logic [7:0]    r_cat;
    logic          r_frameStart;
    logic [7:0]    w_anNext;
    logic [7:0]    w_catNext;
    logic          w_slotEnd;
    logic          w_frameEnd;
    logic          w_hide;
    digit_word_t   w_selWord;
    logic [6:0]    w_seg;

    assign w_slotEnd  = (r_slotCount == LAST_COUNT);
    assign w_frameEnd = w_slotEnd && (r_digitIdx == 3'd7);
    assign w_selWord  = r_snap[r_digitIdx];
    assign w_hide     = !w_selWord[DW_EN] ||
                        (io_disp.blink_mask[r_digitIdx] && io_disp.blink_hide);

    hex_to_seg7 u_hexToSeg7 (
        .i_value (w_selWord[DW_VAL_HI:DW_VAL_LO]),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slotCount <= '0;
            r_digitIdx  <= '0;
        end else if (w_slotEnd) begin
            r_slotCount <= '0;
            r_digitIdx  <= r_digitIdx + 3'd1;
        end else begin
            r_slotCount <= r_slotCount + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Drive values are fixed once at the BLANK->DRIVE edge, which also
    // latches the blink inputs for the rest of the slot.
    always_comb begin
        w_nextState = r_state;
        w_anNext    = r_an;
        w_catNext   = r_cat;
        unique case (r_state)
            BLANK: begin
                if (r_slotCount == BLANK_END) begin
                    w_nextState = DRIVE;
                    if (w_hide) begin
                        w_anNext  = SEG_OFF;
                        w_catNext = SEG_OFF;
                    end else begin
                        w_anNext  = ~(8'h01 << r_digitIdx);
                        w_catNext = {w_selWord[DW_DP], w_seg};
                    end
                end
            end
            DRIVE: begin
                if (w_slotEnd) begin
                    w_nextState = BLANK;
                    w_anNext    = SEG_OFF;
                    w_catNext   = SEG_OFF;
                end
            end
            default: begin
                w_nextState = BLANK;
                w_anNext    = SEG_OFF;
                w_catNext   = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an         <= SEG_OFF;
            r_cat        <= SEG_OFF;
            r_frameStart <= 1'b0;
        end else begin
            r_an         <= w_anNext;
            r_cat        <= w_catNext;
            r_frameStart <= w_frameEnd;
        end
    end

    // Whole-frame capture so a digit update can never tear a scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_frameEnd) begin
            r_snap[0] <= io_disp.d1;
            r_snap[1] <= io_disp.d2;
            r_snap[2] <= io_disp.d3;
            r_snap[3] <= io_disp.d4;
            r_snap[4] <= io_disp.d5;
            r_snap[5] <= io_disp.d6;
            r_snap[6] <= io_disp.d7;
            r_snap[7] <= io_disp.d8;
        end
    end

    assign io_disp.an          = r_an;
    assign io_disp.cat         = r_cat;
    assign io_disp.frame_start = r_frameStart;

endmodule

// File: tb/tb_display_mux_driver.sv
// Directed bench for display_mux_driver with an 8-cycle slot and 2-cycle
// blanking gap; each frame is compared cycle by cycle with hand tables.
`timescale 1ns/1ps
module tb_display_mux_driver;

    localparam int REFRESH_LEN = 8;
    localparam int BLANK_LEN   = 2;

    // Hand-decoded cathodes for digit values 0..7 with dp off.
    localparam logic [7:0] BASE_CAT [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                                             8'h99, 8'h92, 8'h82, 8'hF8};
    localparam logic [7:0] BASE_AN  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                             8'hEF, 8'hDF, 8'hBF, 8'h7F};

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [5:0] dIn [8];
    logic [7:0] blinkMask;
    logic       blinkHide;
    logic [7:0] expAn  [8];
    logic [7:0] expCat [8];
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    display_mux_driver_if dispIf ();

    assign dispIf.d1         = dIn[0];
    assign dispIf.d2         = dIn[1];
    assign dispIf.d3         = dIn[2];
    assign dispIf.d4         = dIn[3];
    assign dispIf.d5         = dIn[4];
    assign dispIf.d6         = dIn[5];
    assign dispIf.d7         = dIn[6];
    assign dispIf.d8         = dIn[7];
    assign dispIf.blink_mask = blinkMask;
    assign dispIf.blink_hide = blinkHide;

    display_mux_driver #(
        .REFRESH_CYCLES (REFRESH_LEN),
        .BLANK_CYCLES   (BLANK_LEN)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .io_disp (dispIf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int digit, input logic [5:0] word);
        dIn[digit-1] = word;
    endtask

    task automatic setExpectBase();
        for (int k = 0; k < 8; k++) begin
            expAn[k]  = BASE_AN[k];
            expCat[k] = BASE_CAT[k];
        end
    endtask

    // Entered at the negedge right after reset release (slot counter 0).
    task automatic darkFrame(input string name);
        for (int i = 1; i < 64; i++) begin
            @(negedge clock);
            checkOutput($sformatf("%s dark an c%0d", name, i), dispIf.an, 8'hFF);
            checkOutput($sformatf("%s dark cat c%0d", name, i), dispIf.cat, 8'hFF);
            checkOutput($sformatf("%s dark fs c%0d", name, i), dispIf.frame_start, 1'b0);
        end
        @(negedge clock);
        checkOutput({name, " first frameStart"}, dispIf.frame_start, 1'b1);
    endtask

    task automatic nextFrame(input string name);
        @(negedge clock);
        checkOutput({name, " frameStart"}, dispIf.frame_start, 1'b1);
    endtask

    // Entered on the frame_start cycle (digit-1 slot, cycle 0).
    task automatic checkFrameBody(input string name);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < REFRESH_LEN; c++) begin
                if (k != 0 || c != 0) begin
                    @(negedge clock);
                    checkOutput($sformatf("%s fs d%0d c%0d", name, k+1, c),
                                dispIf.frame_start, 1'b0);
                end
                if (c < BLANK_LEN) begin
                    checkOutput($sformatf("%s an d%0d c%0d", name, k+1, c), dispIf.an, 8'hFF);
                    checkOutput($sformatf("%s cat d%0d c%0d", name, k+1, c), dispIf.cat, 8'hFF);
                end else begin
                    checkOutput($sformatf("%s an d%0d c%0d", name, k+1, c), dispIf.an, expAn[k]);
                    checkOutput($sformatf("%s cat d%0d c%0d", name, k+1, c), dispIf.cat, expCat[k]);
                end
            end
        end
    endtask

    initial begin
        blinkMask = 8'h00;
        blinkHide = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i + 1, {1'b1, 4'(i), 1'b1});
        end
        repeat (3) @(negedge clock);
        checkOutput("reset an", dispIf.an, 8'hFF);
        checkOutput("reset cat", dispIf.cat, 8'hFF);
        checkOutput("reset fs", dispIf.frame_start, 1'b0);
        reset = 1'b1;
        darkFrame("F0");

        applyStimulus(3, {1'b0, 4'h8, 1'b1});
        setExpectBase();
        checkFrameBody("F1");

        nextFrame("F2");
        applyStimulus(3, {1'b1, 4'h2, 1'b1});
        applyStimulus(1, {1'b1, 4'h8, 1'b0});
        setExpectBase();
        expAn[2]  = 8'hFF;
        expCat[2] = 8'hFF;
        checkFrameBody("F2");

        nextFrame("F3");
        applyStimulus(1, {1'b1, 4'h0, 1'b1});
        setExpectBase();
        expCat[0] = 8'h00;
        checkFrameBody("F3");

        blinkMask = 8'h03;
        blinkHide = 1'b1;
        nextFrame("F4");
        applyStimulus(5, {1'b1, 4'h5, 1'b1});
        setExpectBase();
        expAn[0]  = 8'hFF;
        expCat[0] = 8'hFF;
        expAn[1]  = 8'hFF;
        expCat[1] = 8'hFF;
        checkFrameBody("F4");

        blinkHide = 1'b0;
        nextFrame("F5");
        fork
            begin
                repeat (20) @(negedge clock);
                applyStimulus(5, {1'b1, 4'h9, 1'b1});
            end
        join_none
        setExpectBase();
        expCat[4] = 8'h92;
        checkFrameBody("F5");

        nextFrame("F6");
        setExpectBase();
        expCat[4] = 8'h90;
        checkFrameBody("F6");

        nextFrame("F7");
        repeat (5 * REFRESH_LEN + 4) @(negedge clock);
        checkOutput("pre-reset d6 an", dispIf.an, 8'hDF);
        checkOutput("pre-reset d6 cat", dispIf.cat, 8'h92);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset an", dispIf.an, 8'hFF);
        checkOutput("async reset cat", dispIf.cat, 8'hFF);
        checkOutput("async reset fs", dispIf.frame_start, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        darkFrame("R0");
        setExpectBase();
        expCat[4] = 8'h90;
        checkFrameBody("R1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
